axi_stream_header_edit: RTL and testbench

Parametrised successor to the AXI-Stream header inserter. Per packet, a command either prepends 0..DATA_BYTE_WD header bytes or strips 0..DATA_BYTE_WD leading bytes. The output is repacked so every beat is full except the last. It sits between a packet source and sink on the datapath, one command consumed per packet.

---
 rtl/axi_hdr_edit_pkg.sv | 37 +++
 rtl/byte_realign.sv | 25 ++
 rtl/axi_stream_header_edit.sv | 194 +++++++++++++++++++
 tb/tb_axi_stream_header_edit.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_hdr_edit_pkg.sv
// Shared types and lane helpers for the AXI-Stream header insert/strip editor.
package axi_hdr_edit_pkg;

    localparam int MAX_LANES = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        BODY  = 2'd2,
        TAIL  = 2'd3
    } state_e;

    typedef enum logic {
        MODE_INSERT = 1'b0,
        MODE_STRIP  = 1'b1
    } mode_e;

    // MSB-aligned keep with n lanes set, out of 'lanes' lanes.
    function automatic logic [MAX_LANES-1:0] byte_mask(input int unsigned n, input int unsigned lanes);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (i < lanes && i + n >= lanes) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_LANES-1:0] keep);
        int unsigned c;
        c = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (keep[i]) c = c + 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/byte_realign.sv
// Merges the carried residue with an incoming beat and extracts the next residue.
module byte_realign #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic [DATA_WD-1:0]   resid,
    input  logic [DATA_WD-1:0]   data,
    input  logic [BYTE_CNT_WD:0] k,
    output logic [DATA_WD-1:0]   merged,
    output logic [DATA_WD-1:0]   resid_next
);

    localparam logic [BYTE_CNT_WD:0] LANES = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);

    logic [BYTE_CNT_WD+3:0] sh_k;
    logic [BYTE_CNT_WD+3:0] sh_rest;

    // Residue is held MSB-aligned, so its k valid bytes are always the top k.
    assign sh_k       = {k, 3'b000};
    assign sh_rest    = {LANES - k, 3'b000};
    assign merged     = (resid & ~({DATA_WD{1'b1}} >> sh_k)) | (data >> sh_k);
    assign resid_next = data << sh_rest;

endmodule

// File: rtl/axi_stream_header_edit.sv
// Per-packet header insert / leading-byte strip with repacking to full beats.
//   state | meaning
//   IDLE  | waiting for a command; ready_cmd high
//   FIRST | first input beat of the packet (strip only primes the residue)
//   BODY  | realigning one input beat per cycle
//   TAIL  | flushing residue bytes left over after the last input beat
module axi_stream_header_edit #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_cmd,
    input  logic                    cmd_strip,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic [BYTE_CNT_WD:0]    byte_cnt,
    output logic                    ready_cmd,
    output logic                    drop_pkt
);
    import axi_hdr_edit_pkg::*;

    localparam logic [BYTE_CNT_WD:0]   LANES   = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);
    localparam logic [BYTE_CNT_WD+1:0] LANES_X = (BYTE_CNT_WD + 2)'(DATA_BYTE_WD);

    function automatic logic [DATA_BYTE_WD-1:0] keep_of(input logic [BYTE_CNT_WD+1:0] n);
        return DATA_BYTE_WD'(byte_mask(32'(n), DATA_BYTE_WD));
    endfunction

    function automatic logic [DATA_WD-1:0] bits_of(input logic [DATA_BYTE_WD-1:0] m);
        logic [DATA_WD-1:0] b;
        b = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) b[8*i +: 8] = {8{m[i]}};
        return b;
    endfunction

    state_e                  state_q, state_d;
    mode_e                   mode_q, mode_d;
    logic [BYTE_CNT_WD:0]    k_q, k_d;
    logic [BYTE_CNT_WD:0]    tail_q, tail_d;
    logic [DATA_WD-1:0]      resid_q, resid_d;
    logic                    valid_q, valid_d;
    logic [DATA_WD-1:0]      data_q, data_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic                    last_q, last_d;
    logic                    drop_q, drop_d;

    logic [DATA_WD-1:0]      data_msk;
    logic [DATA_WD-1:0]      merged;
    logic [DATA_WD-1:0]      resid_next;
    logic [BYTE_CNT_WD:0]    n_in;
    logic [BYTE_CNT_WD+1:0]  sum;
    logic                    load_en;
    logic                    unused_keep_insert;

    assign unused_keep_insert = ^keep_insert;

    // Invalid lanes of the last beat are zeroed so they never leak into data_out.
    assign data_msk = data_in & bits_of(keep_in);
    assign n_in     = (BYTE_CNT_WD + 1)'(popcount(MAX_LANES'(keep_in)));
    assign sum      = {1'b0, k_q} + {1'b0, n_in};
    assign load_en  = !valid_q || ready_out;

    byte_realign #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) u_realign (
        .resid      (resid_q),
        .data       (data_msk),
        .k          (k_q),
        .merged     (merged),
        .resid_next (resid_next)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        k_d       = k_q;
        tail_d    = tail_q;
        resid_d   = resid_q;
        valid_d   = valid_q && !ready_out;
        data_d    = data_q;
        keep_d    = keep_q;
        last_d    = last_q;
        drop_d    = 1'b0;
        ready_cmd = (state_q == IDLE);
        ready_in  = (state_q == FIRST || state_q == BODY) && load_en;

        case (state_q)
            IDLE: begin
                if (valid_cmd) begin
                    mode_d  = cmd_strip ? MODE_STRIP : MODE_INSERT;
                    state_d = FIRST;
                    if (cmd_strip) begin
                        k_d     = LANES - byte_cnt;
                        resid_d = '0;
                    end else begin
                        k_d     = byte_cnt;
                        resid_d = data_insert << {LANES - byte_cnt, 3'b000};
                    end
                end
            end
            FIRST, BODY: begin
                if (valid_in && ready_in) begin
                    resid_d = resid_next;
                    if (state_q == FIRST && mode_q == MODE_STRIP) begin
                        if (!last_in) begin
                            state_d = BODY;
                        end else begin
                            state_d = IDLE;
                            if (sum <= LANES_X) begin
                                drop_d = 1'b1;
                            end else begin
                                valid_d = 1'b1;
                                keep_d  = keep_of(sum - LANES_X);
                                data_d  = resid_next & bits_of(keep_of(sum - LANES_X));
                                last_d  = 1'b1;
                            end
                        end
                    end else begin
                        valid_d = 1'b1;
                        if (last_in && sum <= LANES_X) begin
                            keep_d  = keep_of(sum);
                            data_d  = merged & bits_of(keep_of(sum));
                            last_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            keep_d  = '1;
                            data_d  = merged;
                            last_d  = 1'b0;
                            tail_d  = (BYTE_CNT_WD + 1)'(sum - LANES_X);
                            state_d = last_in ? TAIL : BODY;
                        end
                    end
                end
            end
            TAIL: begin
                if (load_en) begin
                    valid_d = 1'b1;
                    keep_d  = keep_of({1'b0, tail_q});
                    data_d  = resid_q & bits_of(keep_of({1'b0, tail_q}));
                    last_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_INSERT;
            k_q     <= '0;
            tail_q  <= '0;
            resid_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
            tail_q  <= tail_d;
            resid_q <= resid_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign keep_out  = keep_q;
    assign last_out  = last_q;
    assign drop_pkt  = drop_q;

endmodule

// File: tb/tb_axi_stream_header_edit.sv
// Self-checking bench: byte-stream reference model against the header editor.
module tb_axi_stream_header_edit;

    localparam int DW = 32;
    localparam int W  = DW / 8;
    localparam int CW = $clog2(W);
    localparam int BW = DW + W + 1;

    typedef logic [BW-1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [W-1:0]  keep_in = '0;
    logic          last_in = 1'b0;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [W-1:0]  keep_out;
    logic          last_out;
    logic          ready_out;
    logic          valid_cmd = 1'b0;
    logic          cmd_strip = 1'b0;
    logic [DW-1:0] data_insert = '0;
    logic [W-1:0]  keep_insert = '0;
    logic [CW:0]   byte_cnt = '0;
    logic          ready_cmd;
    logic          drop_pkt;

    int   n_cmp = 0;
    int   n_err = 0;
    int   drop_cnt = 0;
    int   got_drop = 0;
    bit   exp_drop = 1'b0;
    bit   abort = 1'b0;
    bit   stall_req = 1'b0;
    bit   bp_rand = 1'b0;
    logic bp_bit = 1'b1;

    beat_t      got_q[$];
    beat_t      exp_q[$];
    logic [7:0] pkt_q[$];

    axi_stream_header_edit #(.DATA_WD(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .data_in     (data_in),
        .keep_in     (keep_in),
        .last_in     (last_in),
        .ready_in    (ready_in),
        .valid_out   (valid_out),
        .data_out    (data_out),
        .keep_out    (keep_out),
        .last_out    (last_out),
        .ready_out   (ready_out),
        .valid_cmd   (valid_cmd),
        .cmd_strip   (cmd_strip),
        .data_insert (data_insert),
        .keep_insert (keep_insert),
        .byte_cnt    (byte_cnt),
        .ready_cmd   (ready_cmd),
        .drop_pkt    (drop_pkt)
    );

    always #5 clk = ~clk;

    assign ready_out = !stall_req && bp_bit;

    always @(posedge clk) begin
        #1;
        bp_bit = bp_rand ? ($urandom_range(3) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst_n && valid_out && ready_out) got_q.push_back({last_out, keep_out, data_out});
        if (drop_pkt) drop_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: build the edited byte stream, then cut it into MSB-first beats.
    task automatic model(input bit strip, input int cnt, input logic [DW-1:0] hdr);
        logic [7:0] ob[$];
        beat_t b;
        exp_q.delete();
        if (!strip) for (int i = cnt - 1; i >= 0; i--) ob.push_back(hdr[8*i +: 8]);
        for (int i = 0; i < pkt_q.size(); i++) if (!strip || i >= cnt) ob.push_back(pkt_q[i]);
        exp_drop = (ob.size() == 0);
        for (int i = 0; i < ob.size(); i += W) begin
            b = '0;
            for (int j = 0; j < W && i + j < ob.size(); j++) begin
                b[DW-1-8*j -: 8] = ob[i+j];
                b[DW+W-1-j]      = 1'b1;
            end
            b[DW+W] = (i + W >= ob.size());
            exp_q.push_back(b);
        end
    endtask

    task automatic load_pkt(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                            input logic [DW-1:0] w2, input logic [DW-1:0] w3, input int nbytes);
        logic [4*DW-1:0] all;
        all = {w0, w1, w2, w3};
        pkt_q.delete();
        for (int i = 0; i < nbytes; i++) pkt_q.push_back(all[4*DW-1-8*i -: 8]);
    endtask

    task automatic send_cmd(input bit strip, input int cnt, input logic [DW-1:0] hdr);
        int t;
        t = 0;
        valid_cmd   = 1'b1;
        cmd_strip   = strip;
        byte_cnt    = (CW + 1)'(cnt);
        data_insert = hdr;
        keep_insert = W'((1 << cnt) - 1);
        @(negedge clk);
        while (!ready_cmd && !abort && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 valid_cmd = 1'b0;
    endtask

    task automatic send_beats(input bit gaps);
        int nb;
        nb = (pkt_q.size() + W - 1) / W;
        for (int b = 0; b < nb && !abort; b++) begin
            logic [DW-1:0] d;
            logic [W-1:0]  k;
            int t;
            t = 0;
            d = $urandom;
            k = '0;
            for (int j = 0; j < W; j++) begin
                if (b * W + j < pkt_q.size()) begin
                    d[DW-1-8*j -: 8] = pkt_q[b*W+j];
                    k[W-1-j] = 1'b1;
                end
            end
            if (gaps && $urandom_range(2) == 0) begin
                valid_in = 1'b0;
                @(posedge clk);
                #1;
            end
            valid_in = 1'b1;
            data_in  = d;
            keep_in  = k;
            last_in  = (b == nb - 1);
            @(negedge clk);
            while (!ready_in && !abort && t < 200) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic run_pkt(input bit strip, input int cnt, input logic [DW-1:0] hdr, input bit gaps);
        int t;
        int d0;
        t = 0;
        model(strip, cnt, hdr);
        got_q.delete();
        d0 = drop_cnt;
        send_cmd(strip, cnt, hdr);
        send_beats(gaps);
        while (!abort && t < 400 && drop_cnt == d0 &&
               !(got_q.size() > 0 && got_q[got_q.size()-1][DW+W])) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        got_drop = drop_cnt - d0;
        if (t >= 400 && !abort) begin
            n_cmp++;
            n_err++;
            $display("FAIL pkt_timeout: got %0d beats, required last beat or drop", got_q.size());
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp += 7;
        if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid_out: got %b required 0", valid_out); end
        if (data_out !== '0) begin n_err++; $display("FAIL reset_data_out: got %h required 0", data_out); end
        if (keep_out !== '0) begin n_err++; $display("FAIL reset_keep_out: got %b required 0", keep_out); end
        if (last_out !== 1'b0) begin n_err++; $display("FAIL reset_last_out: got %b required 0", last_out); end
        if (drop_pkt !== 1'b0) begin n_err++; $display("FAIL reset_drop_pkt: got %b required 0", drop_pkt); end
        if (ready_in !== 1'b0) begin n_err++; $display("FAIL reset_ready_in: got %b required 0", ready_in); end
        if (ready_cmd !== 1'b1) begin n_err++; $display("FAIL reset_ready_cmd: got %b required 1", ready_cmd); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_insert;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin
                load_pkt(32'h11223344, 32'h55667788, 32'h99AABBCC, 32'h0, 12);
                run_pkt(1'b0, 2, 32'h0000AABB, 1'b0);
            end else begin
                load_pkt(32'h11223344, 32'h55660000, 32'h0, 32'h0, 6);
                run_pkt(1'b0, 3, 32'h00A1A2A3, 1'b0);
            end
            n_cmp++;
            if (got_q.size() != exp_q.size()) begin
                n_err++;
                $display("FAIL insert%0d_beats: got %0d required %0d", c, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL insert%0d_beat%0d: got %h required %h", c, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_strip;
        for (int c = 0; c < 3; c++) begin
            if (c == 0) begin
                load_pkt(32'h11223344, 32'h55667788, 32'h0, 32'h0, 7);
                run_pkt(1'b1, 1, 32'h0, 1'b0);
            end else if (c == 1) begin
                load_pkt(32'h11223344, 32'h0, 32'h0, 32'h0, 2);
                run_pkt(1'b1, 3, 32'h0, 1'b0);
            end else begin
                load_pkt(32'h11223344, 32'h0, 32'h0, 32'h0, 4);
                run_pkt(1'b1, 3, 32'h0, 1'b0);
            end
            n_cmp += 2;
            if (got_q.size() != exp_q.size()) begin
                n_err++;
                $display("FAIL strip%0d_beats: got %0d required %0d", c, got_q.size(), exp_q.size());
            end
            if (got_drop != int'(exp_drop)) begin
                n_err++;
                $display("FAIL strip%0d_drop_pulses: got %0d required %0d", c, got_drop, int'(exp_drop));
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL strip%0d_beat%0d: got %h required %h", c, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [BW:0] snap;
        logic [BW:0] cur;
        int t;
        for (int c = 0; c < 2; c++) begin
            load_pkt($urandom, $urandom, $urandom, $urandom, 16);
            got_q.delete();
            if (c == 0) begin
                fork
                    run_pkt(1'b0, 4, $urandom, 1'b0);
                    begin
                        t = 0;
                        while (got_q.size() < 2 && t < 200) begin
                            @(negedge clk);
                            t++;
                        end
                        @(posedge clk);
                        #1 stall_req = 1'b1;
                        snap = '0;
                        for (int i = 0; i < 5; i++) begin
                            @(negedge clk);
                            cur = {valid_out, last_out, keep_out, data_out};
                            if (i == 0) begin
                                snap = cur;
                                n_cmp++;
                                if (valid_out !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b required 1", valid_out); end
                            end else begin
                                n_cmp++;
                                if (cur !== snap) begin n_err++; $display("FAIL stall_hold%0d: got %h required %h", i, cur, snap); end
                            end
                            n_cmp += 2;
                            if (ready_in !== 1'b0) begin n_err++; $display("FAIL stall_ready_in%0d: got %b required 0", i, ready_in); end
                            if (ready_cmd !== 1'b0) begin n_err++; $display("FAIL stall_ready_cmd%0d: got %b required 0", i, ready_cmd); end
                        end
                        @(posedge clk);
                        #1 stall_req = 1'b0;
                    end
                join
            end else begin
                run_pkt(1'b0, 0, $urandom, 1'b0);
            end
            n_cmp++;
            if (got_q.size() != exp_q.size()) begin
                n_err++;
                $display("FAIL b2b%0d_beats: got %0d required %0d", c, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL b2b%0d_beat%0d: got %h required %h", c, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int t;
        got_q.delete();
        load_pkt(32'h11223344, 32'h55667788, 32'h99AABBCC, 32'h0, 12);
        fork
            run_pkt(1'b0, 2, 32'h0000AABB, 1'b0);
            begin
                t = 0;
                while (got_q.size() < 1 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk);
                #1 rst_n = 1'b0;
                abort = 1'b1;
                #1;
                n_cmp += 6;
                if (valid_out !== 1'b0) begin n_err++; $display("FAIL midrst_valid_out: got %b required 0", valid_out); end
                if (data_out !== '0) begin n_err++; $display("FAIL midrst_data_out: got %h required 0", data_out); end
                if (keep_out !== '0) begin n_err++; $display("FAIL midrst_keep_out: got %b required 0", keep_out); end
                if (last_out !== 1'b0) begin n_err++; $display("FAIL midrst_last_out: got %b required 0", last_out); end
                if (ready_in !== 1'b0) begin n_err++; $display("FAIL midrst_ready_in: got %b required 0", ready_in); end
                if (ready_cmd !== 1'b1) begin n_err++; $display("FAIL midrst_ready_cmd: got %b required 1", ready_cmd); end
            end
        join
        valid_in  = 1'b0;
        last_in   = 1'b0;
        valid_cmd = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        abort = 1'b0;
        @(posedge clk);
        #1;
        load_pkt(32'h11223344, 32'h55667788, 32'h0, 32'h0, 7);
        run_pkt(1'b1, 1, 32'h0, 1'b0);
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL midrst_after_beats: got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL midrst_after_beat%0d: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random;
        bit strip;
        int cnt;
        int len;
        bp_rand = 1'b1;
        for (int p = 0; p < 40; p++) begin
            strip = 1'($urandom_range(1));
            cnt   = $urandom_range(W);
            len   = $urandom_range(12, 1);
            pkt_q.delete();
            for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
            run_pkt(strip, cnt, $urandom, 1'b1);
            n_cmp += 2;
            if (got_q.size() != exp_q.size()) begin
                n_err++;
                $display("FAIL rand%0d_beats: strip=%0d cnt=%0d len=%0d got %0d required %0d",
                         p, strip, cnt, len, got_q.size(), exp_q.size());
            end
            if (got_drop != int'(exp_drop)) begin
                n_err++;
                $display("FAIL rand%0d_drop_pulses: got %0d required %0d", p, got_drop, int'(exp_drop));
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL rand%0d_beat%0d: got %h required %h", p, i, got_q[i], exp_q[i]);
                end
            end
        end
        bp_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_insert();
        test_strip();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
